// File: rtl/ide_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ide_pkg: shared IDE PIO states, mode-0 cycle defaults and port indices.
// Rev 1.0
// ---------------------------------------------------------------------------
package ide_pkg;

  typedef enum logic [2:0] {
    IDE_IDLE    = 3'd0,
    IDE_SETUP   = 3'd1,
    IDE_STROBE  = 3'd2,
    IDE_HOLD    = 3'd3,
    IDE_RECOVER = 3'd4
  } ide_state_e;

  localparam int IDE_PIO0_T1   = 2;
  localparam int IDE_PIO0_T2   = 5;
  localparam int IDE_PIO0_T4   = 1;
  localparam int IDE_PIO0_TEOC = 1;

  localparam logic IDE_PORT_CPU = 1'b0;
  localparam logic IDE_PORT_DMA = 1'b1;

  localparam int IDE_CNT_W = 8;

  // Phase counters count down to zero, so an N-cycle phase loads N-1.
  function automatic logic [IDE_CNT_W-1:0] ide_cnt(input int n);
    return IDE_CNT_W'(n - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ide_rr_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ide_rr_arb: two-way round-robin picker; last-granted pointer resets to DMA.
// Rev 1.0
// ---------------------------------------------------------------------------
module ide_rr_arb
  import ide_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       any_req,
  output logic       winner
);

  logic last_q, last_d;

  always_comb begin
    any_req = |req;
    if (req == 2'b11) begin
      winner = ~last_q;
    end else if (req[IDE_PORT_CPU]) begin
      winner = IDE_PORT_CPU;
    end else begin
      winner = IDE_PORT_DMA;
    end
    last_d = last_q;
    if (take && any_req) begin
      last_d = winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDE_PORT_DMA;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ide_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ide_arbiter: shares the IDE PIO bus between two requesters and sequences
// setup/strobe/hold/recovery. Optional IORDY timeout: IDE_WAIT_TIMEOUT_EN. Rev 1.0
// ---------------------------------------------------------------------------
module ide_arbiter
  import ide_pkg::*;
#(
  parameter int PIO_T1       = IDE_PIO0_T1,
  parameter int PIO_T2       = IDE_PIO0_T2,
  parameter int PIO_T4       = IDE_PIO0_T4,
  parameter int PIO_TEOC     = IDE_PIO0_TEOC,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] REQ,
  input  logic [1:0] RW,
  input  logic [1:0] CSSEL,
  input  logic [2:0] ADDR0,
  input  logic [2:0] ADDR1,
  input  logic       IDEWAIT,
  output logic [1:0] ACK,
  output logic [1:0] GNT,
  output logic       RDLATCH,
  output logic       ERR,
  output logic [1:0] IDECS,
  output logic [2:0] IDEA,
  output logic       IOR,
  output logic       IOW,
  output logic       BUSY
);

  ide_state_e           state_q, state_d;
  logic [IDE_CNT_W-1:0] cnt_q, cnt_d;
  logic                 rw_q, rw_d, cs_q, cs_d;
  logic [2:0]           addr_q, addr_d;
  logic [1:0]           gnt_q, gnt_d, ack_q, ack_d, idecs_q, idecs_d;
  logic                 last_q, last_d, rdl_q, rdl_d;
  logic                 ior_q, ior_d, iow_q, iow_d, busy_q, busy_d;
  logic                 timeout_d;
  logic                 any_req, winner;

`ifdef IDE_WAIT_TIMEOUT_EN
  localparam int EXT_W = $clog2(WAIT_TIMEOUT + 1);
  logic [EXT_W-1:0] ext_q, ext_d;
  logic             err_pend_q, err_pend_d, err_q, err_d;
`endif

  ide_rr_arb u_arb (
    .clk     (CLK),
    .rst_n   (RESET),
    .req     (REQ),
    .take    (state_q == IDE_IDLE),
    .any_req (any_req),
    .winner  (winner)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    cs_d    = cs_q;
    addr_d  = addr_q;
    gnt_d   = gnt_q;
    ack_d   = 2'b00;
`ifdef IDE_WAIT_TIMEOUT_EN
    ext_d   = ext_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDE_IDLE: begin
        if (any_req) begin
          state_d       = IDE_SETUP;
          cnt_d         = ide_cnt(PIO_T1);
          rw_d          = RW[winner];
          cs_d          = CSSEL[winner];
          addr_d        = (winner == IDE_PORT_DMA) ? ADDR1 : ADDR0;
          gnt_d         = 2'b00;
          gnt_d[winner] = 1'b1;
        end
      end
      IDE_SETUP: begin
        if (cnt_q == '0) begin
          state_d = IDE_STROBE;
          cnt_d   = ide_cnt(PIO_T2);
`ifdef IDE_WAIT_TIMEOUT_EN
          ext_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      IDE_STROBE: begin
        // last_q was decided one edge early so RDLATCH can sit on the final strobe cycle.
        if (last_q) begin
          state_d = IDE_HOLD;
          cnt_d   = ide_cnt(PIO_T4);
          ack_d   = gnt_q;
`ifdef IDE_WAIT_TIMEOUT_EN
          err_d   = err_pend_q;
`endif
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
`ifdef IDE_WAIT_TIMEOUT_EN
        else begin
          ext_d = ext_q + 1'b1;
        end
`endif
      end
      IDE_HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDE_RECOVER;
          cnt_d   = ide_cnt(PIO_TEOC);
          gnt_d   = 2'b00;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      IDE_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = IDE_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDE_IDLE;
    endcase

`ifdef IDE_WAIT_TIMEOUT_EN
    timeout_d  = (ext_d == EXT_W'(WAIT_TIMEOUT));
`else
    timeout_d  = 1'b0;
`endif
    last_d = (state_d == IDE_STROBE) && (cnt_d == '0) && (IDEWAIT || timeout_d);
`ifdef IDE_WAIT_TIMEOUT_EN
    err_pend_d = last_d && !IDEWAIT;
`endif
    rdl_d   = last_d && rw_d;
    ior_d   = !((state_d == IDE_STROBE) && rw_d);
    iow_d   = !((state_d == IDE_STROBE) && !rw_d);
    busy_d  = (state_d != IDE_IDLE);
    idecs_d = 2'b11;
    if (state_d inside {IDE_SETUP, IDE_STROBE, IDE_HOLD}) begin
      idecs_d[cs_d] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDE_IDLE;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      cs_q       <= 1'b0;
      addr_q     <= 3'b000;
      gnt_q      <= 2'b00;
      ack_q      <= 2'b00;
      idecs_q    <= 2'b11;
      last_q     <= 1'b0;
      rdl_q      <= 1'b0;
      ior_q      <= 1'b1;
      iow_q      <= 1'b1;
      busy_q     <= 1'b0;
`ifdef IDE_WAIT_TIMEOUT_EN
      ext_q      <= '0;
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      cs_q       <= cs_d;
      addr_q     <= addr_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      idecs_q    <= idecs_d;
      last_q     <= last_d;
      rdl_q      <= rdl_d;
      ior_q      <= ior_d;
      iow_q      <= iow_d;
      busy_q     <= busy_d;
`ifdef IDE_WAIT_TIMEOUT_EN
      ext_q      <= ext_d;
      err_pend_q <= err_pend_d;
      err_q      <= err_d;
`endif
    end
  end

  assign ACK     = ack_q;
  assign GNT     = gnt_q;
  assign RDLATCH = rdl_q;
  assign IDECS   = idecs_q;
  assign IDEA    = addr_q;
  assign IOR     = ior_q;
  assign IOW     = iow_q;
  assign BUSY    = busy_q;
`ifdef IDE_WAIT_TIMEOUT_EN
  assign ERR     = err_q;
`else
  assign ERR     = 1'b0;
`endif

endmodule
`default_nettype wire
